// File: rtl/elevator_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : elevator_scheduler_if
// Description : Request/status bundle between the elevator scheduler and its
//               surroundings (buttons, display mux, car status).
// Revision    : 1.0  initial release
// ============================================================================
interface elevator_scheduler_if #(
    parameter int FLOORS = 8
);
    localparam int c_FW = $clog2(FLOORS);

    logic [FLOORS-1:0] req;
    logic [c_FW-1:0]   floor;
    logic [1:0]        state_code;
    logic              door_open;
    logic              moving;
    logic [FLOORS-1:0] pending;
    logic              disp_sel;

    modport master (
        output req,
        input  floor, state_code, door_open, moving, pending, disp_sel
    );

    modport slave (
        input  req,
        output floor, state_code, door_open, moving, pending, disp_sel
    );
endinterface
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : elevator_scheduler
// Description : SCAN-style car scheduler with request latch, door timer and
//               free-running 7-segment display select.
// Revision    : 1.0  initial release
// ============================================================================
module elevator_scheduler #(
    parameter int FLOORS        = 8,
    parameter int TRAVEL_CYCLES = 50_000_000,
    parameter int DOOR_CYCLES   = 100_000_000,
    parameter int DISP_CYCLES   = 250_000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    elevator_scheduler_if.slave bus
);
    localparam int c_FW = $clog2(FLOORS);
    localparam int c_TW = $clog2(TRAVEL_CYCLES);
    localparam int c_DW = $clog2(DOOR_CYCLES);
    localparam int c_SW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [c_FW-1:0] c_TOP         = c_FW'(FLOORS - 1);
    localparam logic [c_TW-1:0] c_TRAVEL_LAST = c_TW'(TRAVEL_CYCLES - 1);
    localparam logic [c_DW-1:0] c_DOOR_LAST   = c_DW'(DOOR_CYCLES - 1);
    localparam logic [c_SW-1:0] c_DISP_LAST   = c_SW'(DISP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10,
        S_DOOR = 2'b11
    } state_t;

    function automatic logic [FLOORS-1:0] f_onehot(input logic [c_FW-1:0] f);
        return FLOORS'(1) << f;
    endfunction

    function automatic logic f_any_above(input logic [FLOORS-1:0] v, input logic [c_FW-1:0] f);
        return |(v & ~((f_onehot(f) << 1) - FLOORS'(1)));
    endfunction

    function automatic logic f_any_below(input logic [FLOORS-1:0] v, input logic [c_FW-1:0] f);
        return |(v & (f_onehot(f) - FLOORS'(1)));
    endfunction

    state_t            r_state, w_state_nxt;
    logic [c_FW-1:0]   r_floor, w_floor_nxt;
    logic [FLOORS-1:0] r_pending;
    logic              r_last_up, w_last_up_nxt;
    logic [c_TW-1:0]   r_travel_cnt, w_travel_nxt;
    logic [c_DW-1:0]   r_door_cnt, w_door_nxt;
    logic              r_door_open, r_moving;
    logic [c_SW-1:0]   r_disp_cnt;
    logic              r_disp_sel;

    logic [FLOORS-1:0] w_here, w_req_eff, w_live, w_clear, w_step_hot;
    logic [c_FW-1:0]   w_step_floor;
    logic              w_hold, w_up_ok, w_down_ok, w_step_ahead;

    // The current floor's button is ignored while the door is open; it only
    // keeps the door open longer.
    always_comb begin
        w_here       = f_onehot(r_floor);
        w_hold       = (r_state == S_DOOR) && |(bus.req & w_here);
        w_req_eff    = bus.req & ~((r_state == S_DOOR) ? w_here : '0);
        w_live       = r_pending | w_req_eff;
        w_step_floor = (r_state == S_DOWN) ? r_floor - c_FW'(1) : r_floor + c_FW'(1);
        w_step_hot   = f_onehot(w_step_floor);
        w_up_ok      = f_any_above(w_live, r_floor) && (r_floor != c_TOP);
        w_down_ok    = f_any_below(w_live, r_floor) && (r_floor != '0);
        w_step_ahead = (r_state == S_UP) ? f_any_above(w_live, w_step_floor)
                                         : f_any_below(w_live, w_step_floor);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_floor_nxt   = r_floor;
        w_travel_nxt  = r_travel_cnt;
        w_door_nxt    = r_door_cnt;
        w_last_up_nxt = r_last_up;
        w_clear       = '0;
        case (r_state)
            S_IDLE: begin
                w_travel_nxt = '0;
                w_door_nxt   = '0;
                if (|(w_live & w_here)) begin
                    w_state_nxt = S_DOOR;
                    w_clear     = w_here;
                end else if (w_up_ok && (r_last_up || !w_down_ok)) begin
                    w_state_nxt   = S_UP;
                    w_last_up_nxt = 1'b1;
                end else if (w_down_ok) begin
                    w_state_nxt   = S_DOWN;
                    w_last_up_nxt = 1'b0;
                end
            end
            S_UP, S_DOWN: begin
                if (r_travel_cnt == c_TRAVEL_LAST) begin
                    w_floor_nxt  = w_step_floor;
                    w_travel_nxt = '0;
                    if (|(w_live & w_step_hot)) begin
                        w_state_nxt = S_DOOR;
                        w_clear     = w_step_hot;
                        w_door_nxt  = '0;
                    end else if (!w_step_ahead) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_travel_nxt = r_travel_cnt + c_TW'(1);
                end
            end
            S_DOOR: begin
                if (w_hold) begin
                    w_door_nxt = '0;
                end else if (r_door_cnt == c_DOOR_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_door_nxt  = '0;
                end else begin
                    w_door_nxt = r_door_cnt + c_DW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_floor      <= '0;
            r_pending    <= '0;
            r_last_up    <= 1'b1;
            r_travel_cnt <= '0;
            r_door_cnt   <= '0;
            r_door_open  <= 1'b0;
            r_moving     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_floor      <= w_floor_nxt;
            r_pending    <= w_live & ~w_clear;
            r_last_up    <= w_last_up_nxt;
            r_travel_cnt <= w_travel_nxt;
            r_door_cnt   <= w_door_nxt;
            r_door_open  <= (w_state_nxt == S_DOOR);
            r_moving     <= (w_state_nxt == S_UP) || (w_state_nxt == S_DOWN);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp_cnt <= '0;
            r_disp_sel <= 1'b0;
        end else if (r_disp_cnt == c_DISP_LAST) begin
            r_disp_cnt <= '0;
            r_disp_sel <= ~r_disp_sel;
        end else begin
            r_disp_cnt <= r_disp_cnt + c_SW'(1);
        end
    end

    assign bus.floor      = r_floor;
    assign bus.state_code = r_state;
    assign bus.door_open  = r_door_open;
    assign bus.moving     = r_moving;
    assign bus.pending    = r_pending;
    assign bus.disp_sel   = r_disp_sel;
endmodule
`default_nettype wire
